adc_spi_responder: RTL and testbench
====================================

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth for n_cs/sclk/sdio_i (legal 2..4).
REQ-002 aclk  input  1  system clock; all logic rising-edge aclk.
REQ-003 aresetn  input  1  reset, asynchronous, active-low.
REQ-004 n_cs  input  1  SPI chip select, active-low, asynchronous to aclk.
REQ-005 sclk  input  1  SPI clock, asynchronous to aclk; master shifts on rising edge.
REQ-006 sdio_i  input  1  3-wire SDIO input path.
REQ-007 sdio_o  output  1  3-wire SDIO output path (read data).
REQ-008 sdio_t  output  1  SDIO tristate control, 1 = released (input), 0 = driving.
REQ-009 reg_pwr, reg_timing, reg_outmode, reg_format  output  8 each  contents of registers 0x01..0x04.
REQ-010 wr_strobe  output  1  one-cycle pulse on each committed write.
REQ-011 wr_addr  output  7  address of last committed write, valid with and after wr_strobe.
REQ-012 frame_err  output  1  one-cycle pulse on aborted frame.

Function
REQ-013 Frame: 16 bits MSB first on sclk rising edges; bit15 R/W (1 = read), bits14:8 address A6..A0, bits7:0 data.
REQ-014 Inputs synchronized by SYNC_STAGES flops; sclk edges detected on synchronized signal; sclk high and low phases each >= SYNC_STAGES+1 aclk cycles.
REQ-015 FSM states: IDLE, HDR, WDATA, RDATA, HOLD.
REQ-016 IDLE -> HDR on synchronized n_cs falling; bit counter cleared to 0.
REQ-017 HDR: shift sdio_i on each sclk rising edge; after 8th edge -> WDATA if R/W=0, RDATA if R/W=1.
REQ-018 WDATA: shift 8 data bits; on 16th edge commit one aclk cycle later, -> HOLD.
REQ-019 Commit: address 0x01..0x04 loads target register, wr_strobe=1, wr_addr updated; address 0x00 with D7=1 clears registers 0x01..0x04 to 0x00, wr_strobe=1; other addresses ignored, no strobe.
REQ-020 RDATA: on each sclk falling edge starting after 8th rising edge, drive next bit D7..D0 on sdio_o with sdio_t=0; first bit valid before 9th rising edge.
REQ-021 Read data: registers 0x01..0x04 return contents; address 0x00 and unmapped return 0x00.
REQ-022 After 16th rising edge in RDATA -> HOLD; sdio_t=1 on the following falling edge or n_cs rising, whichever first.
REQ-023 HOLD: extra sclk edges ignored until n_cs rises -> IDLE.
REQ-024 n_cs rising from any state -> IDLE, sdio_t=1 within 1 aclk cycle of detection; if bit count 1..15: no commit, frame_err pulse.
REQ-025 n_cs rising with bit count 0: no error, no action.
REQ-026 sclk edge coincident with n_cs rising detection: n_cs wins, edge discarded.
REQ-027 Back-to-back frames with n_cs high >= SYNC_STAGES+1 cycles handled independently.

Reset
REQ-028 aresetn low: all registers 0x00, sdio_t=1, sdio_o=0, wr_strobe=0, wr_addr=0, frame_err=0, FSM IDLE, synchronizers to idle levels (n_cs=1, sclk=0, sdio=0).
REQ-029 Reset mid-frame discards frame; after release, frame recognized only on fresh n_cs falling edge.

Structure
REQ-030 Shared package holds register addresses 0x00..0x04, FSM state encodings, frame width 16, header width 8.
REQ-031 One sub-module spi_sync_edge: parameterized synchronizer plus rise/fall pulse outputs, instantiated for n_cs and sclk; sdio_i uses plain synchronizer.

Verification
REQ-032 Write 0x0100,0x0201,0x0302,0x0400 as separate frames -> reg_pwr=0x00, reg_timing=0x01, reg_outmode=0x02, reg_format=0x00, four wr_strobe pulses, wr_addr 1,2,3,4.
REQ-033 Write 0x0355 then read 0x8300 -> sdio_o bits 0,1,0,1,0,1,0,1 over data phase, sdio_t=0 only during data phase.
REQ-034 Write 0x04AA, then n_cs high after 10 bits of 0x0411 -> reg_format stays 0xAA, frame_err one pulse, no wr_strobe.
REQ-035 Write 0x0080 after loading registers -> all four outputs 0x00, wr_strobe pulse, wr_addr=0x00.
REQ-036 Write 0x7F12 and read 0x8500 -> no strobe, read returns 0x00, no register change.
REQ-037 Assert aresetn low mid-read at bit 12 -> sdio_t=1 immediately, registers 0x00; next full write 0x0201 commits normally.

Source files
------------

// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the 3-wire SPI register responder: frame geometry, register map, FSM states.
// Register file is carried as one packed struct so read mux and clear-all stay in one place.
package adc_spi_responder_pkg;

    localparam int FRAME_W = 16;
    localparam int HDR_W   = 8;
    localparam int DATA_W  = FRAME_W - HDR_W;

    localparam logic [6:0] ADDR_CTRL    = 7'h00;
    localparam logic [6:0] ADDR_PWR     = 7'h01;
    localparam logic [6:0] ADDR_TIMING  = 7'h02;
    localparam logic [6:0] ADDR_OUTMODE = 7'h03;
    localparam logic [6:0] ADDR_FORMAT  = 7'h04;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        HOLD  = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] format;
        logic [7:0] outmode;
        logic [7:0] timing;
        logic [7:0] pwr;
    } regs_t;

    // Control register and unmapped addresses read back as zero.
    function automatic logic [DATA_W-1:0] read_reg(input regs_t regs, input logic [6:0] addr);
        case (addr)
            ADDR_PWR:     read_reg = regs.pwr;
            ADDR_TIMING:  read_reg = regs.timing;
            ADDR_OUTMODE: read_reg = regs.outmode;
            ADDR_FORMAT:  read_reg = regs.format;
            default:      read_reg = '0;
        endcase
    endfunction

endpackage

// File: rtl/adc_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses; edges appear STAGES cycles after the pin.
// No backpressure; edges are suppressed until the chain has flushed its reset value after reset.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   flush_q;
    logic              level;
    logic              live;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q  <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            flush_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], din};
            prev_q  <= sync_q[STAGES-1];
            flush_q <= {flush_q[STAGES-1:0], 1'b1};
        end
    end

    // Both the level and its delayed copy must hold real pin samples before an edge is trusted,
    // otherwise a reset taken mid-frame would fake an n_cs falling edge on release.
    assign level = sync_q[STAGES-1];
    assign live  = flush_q[STAGES];
    assign rise  = live & level & ~prev_q;
    assign fall  = live & ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// 3-wire SPI slave exposing four 8-bit config registers; writes commit 1 aclk after the 16th sclk rise.
// No backpressure: the SPI master owns timing, read bits are launched on each synchronized sclk fall.
module adc_spi_responder
    import adc_spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       n_cs,
    input  logic       sclk,
    input  logic       sdio_i,
    output logic       sdio_o,
    output logic       sdio_t,
    output logic [7:0] reg_pwr,
    output logic [7:0] reg_timing,
    output logic [7:0] reg_outmode,
    output logic [7:0] reg_format,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic       frame_err
);

    localparam logic [4:0] LAST_HDR_BIT   = 5'(HDR_W - 1);
    localparam logic [4:0] LAST_FRAME_BIT = 5'(FRAME_W - 1);
    localparam logic [4:0] FRAME_BITS     = 5'(FRAME_W);

    logic ncs_rise;
    logic ncs_fall;
    logic sclk_rise;
    logic sclk_fall;

    logic [SYNC_STAGES-1:0] sdio_sr;
    logic                   sdio_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     (n_cs),
        .rise    (ncs_rise),
        .fall    (ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .din     (sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // Same depth as the sclk chain so the data bit lines up with its detected rising edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sdio_sr <= '0;
        end else begin
            sdio_sr <= {sdio_sr[SYNC_STAGES-2:0], sdio_i};
        end
    end
    assign sdio_sync = sdio_sr[SYNC_STAGES-1];

    state_t             state;
    state_t             state_nx;
    logic [4:0]         bit_cnt;
    // R/W bit is consumed on the 8th edge, so only address and data are retained.
    logic [FRAME_W-2:0] frame_sr;
    logic [DATA_W-1:0]  rd_sr;
    logic               commit_pend;
    regs_t              regs;

    logic start;
    logic shift_en;
    logic load_rd;
    logic drive_bit;
    logic release_sdio;
    logic commit_set;
    logic abort_err;

    always_comb begin
        state_nx     = state;
        start        = 1'b0;
        shift_en     = 1'b0;
        load_rd      = 1'b0;
        drive_bit    = 1'b0;
        release_sdio = 1'b0;
        commit_set   = 1'b0;
        abort_err    = 1'b0;
        // n_cs deassertion overrides any sclk edge seen in the same cycle.
        if (ncs_rise) begin
            state_nx     = IDLE;
            release_sdio = 1'b1;
            abort_err    = (bit_cnt != 5'd0) && (bit_cnt < FRAME_BITS);
        end else begin
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state_nx = HDR;
                        start    = 1'b1;
                    end
                end
                HDR: begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_HDR_BIT) begin
                            if (frame_sr[HDR_W-2]) begin
                                state_nx = RDATA;
                                load_rd  = 1'b1;
                            end else begin
                                state_nx = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_FRAME_BIT) begin
                            state_nx   = HOLD;
                            commit_set = 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == LAST_FRAME_BIT) begin
                            state_nx = HOLD;
                        end
                    end else if (sclk_fall) begin
                        drive_bit = 1'b1;
                    end
                end
                HOLD: begin
                    if (sclk_fall) begin
                        release_sdio = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    logic [6:0]        commit_addr;
    logic [DATA_W-1:0] commit_data;
    assign commit_addr = frame_sr[FRAME_W-2:DATA_W];
    assign commit_data = frame_sr[DATA_W-1:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            frame_sr    <= '0;
            rd_sr       <= '0;
            commit_pend <= 1'b0;
            regs        <= '0;
            sdio_o      <= 1'b0;
            sdio_t      <= 1'b1;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            commit_pend <= commit_set;
            frame_err   <= abort_err;
            wr_strobe   <= 1'b0;

            if (start || ncs_rise) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (start) begin
                frame_sr <= '0;
            end else if (shift_en) begin
                frame_sr <= {frame_sr[FRAME_W-3:0], sdio_sync};
            end

            // Address LSB is still on the pin path, so it is spliced in directly.
            if (load_rd) begin
                rd_sr <= read_reg(regs, {frame_sr[HDR_W-3:0], sdio_sync});
            end else if (drive_bit) begin
                rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
            end

            if (release_sdio) begin
                sdio_t <= 1'b1;
                sdio_o <= 1'b0;
            end else if (drive_bit) begin
                sdio_t <= 1'b0;
                sdio_o <= rd_sr[DATA_W-1];
            end

            if (commit_pend) begin
                case (commit_addr)
                    ADDR_PWR: begin
                        regs.pwr  <= commit_data;
                        wr_strobe <= 1'b1;
                        wr_addr   <= commit_addr;
                    end
                    ADDR_TIMING: begin
                        regs.timing <= commit_data;
                        wr_strobe   <= 1'b1;
                        wr_addr     <= commit_addr;
                    end
                    ADDR_OUTMODE: begin
                        regs.outmode <= commit_data;
                        wr_strobe    <= 1'b1;
                        wr_addr      <= commit_addr;
                    end
                    ADDR_FORMAT: begin
                        regs.format <= commit_data;
                        wr_strobe   <= 1'b1;
                        wr_addr     <= commit_addr;
                    end
                    ADDR_CTRL: begin
                        if (commit_data[DATA_W-1]) begin
                            regs      <= '0;
                            wr_strobe <= 1'b1;
                            wr_addr   <= commit_addr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign reg_pwr     = regs.pwr;
    assign reg_timing  = regs.timing;
    assign reg_outmode = regs.outmode;
    assign reg_format  = regs.format;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: bit-banged 3-wire SPI frames with hand-computed expectations.
module tb_adc_spi_responder;

    localparam int PH = 6;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       n_cs = 1'b1;
    logic       sclk = 1'b0;
    logic       sdio_i = 1'b0;
    logic       sdio_o;
    logic       sdio_t;
    logic [7:0] reg_pwr;
    logic [7:0] reg_timing;
    logic [7:0] reg_outmode;
    logic [7:0] reg_format;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;

    adc_spi_responder #(.SYNC_STAGES(2)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .n_cs        (n_cs),
        .sclk        (sclk),
        .sdio_i      (sdio_i),
        .sdio_o      (sdio_o),
        .sdio_t      (sdio_t),
        .reg_pwr     (reg_pwr),
        .reg_timing  (reg_timing),
        .reg_outmode (reg_outmode),
        .reg_format  (reg_format),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .frame_err   (frame_err)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Master shifts on sclk rise; read bits are sampled just before each rise.
    // t_bad counts samples where sdio_t disagreed with the phase (driven only in a read's data phase).
    task automatic spi_xfer(input logic [15:0] word, input int nbits, input bit end_cs,
                            output logic [7:0] rd, output int t_bad);
        logic exp_t;
        rd = '0;
        t_bad = 0;
        n_cs = 1'b0;
        wait_cyc(PH);
        for (int i = 0; i < nbits; i++) begin
            sdio_i = word[15-i];
            wait_cyc(PH);
            exp_t = (i >= 8 && word[15]) ? 1'b0 : 1'b1;
            if (i >= 8) rd = {rd[6:0], sdio_o};
            if (sdio_t !== exp_t) t_bad++;
            sclk = 1'b1;
            wait_cyc(PH);
            sclk = 1'b0;
        end
        if (end_cs) begin
            wait_cyc(PH);
            n_cs = 1'b1;
            sdio_i = 1'b0;
            wait_cyc(3 * PH);
        end
    endtask

    task automatic spi_write(input logic [15:0] word);
        logic [7:0] rd;
        int tb;
        spi_xfer(word, 16, 1'b1, rd, tb);
        chk("write_sdio_t_released", tb, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        int tbad;

        wait_cyc(3);
        chk("rst_sdio_t", sdio_t, 1);
        chk("rst_sdio_o", sdio_o, 0);
        chk("rst_regs", {reg_pwr, reg_timing, reg_outmode, reg_format}, 32'h0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_frame_err", frame_err, 0);
        aresetn = 1'b1;
        wait_cyc(10);

        spi_write(16'h0100);
        chk("wa_addr1", wr_addr, 7'h01);
        spi_write(16'h0201);
        chk("wa_addr2", wr_addr, 7'h02);
        spi_write(16'h0302);
        chk("wa_addr3", wr_addr, 7'h03);
        spi_write(16'h0400);
        chk("wa_addr4", wr_addr, 7'h04);
        chk("wa_regs", {reg_pwr, reg_timing, reg_outmode, reg_format}, 32'h00010200);
        chk("wa_strobes", strobe_cnt, 4);
        chk("wa_no_err", err_cnt, 0);

        spi_write(16'h0355);
        chk("rb_outmode", reg_outmode, 8'h55);
        spi_xfer(16'h8300, 16, 1'b1, rd, tbad);
        chk("rb_data", rd, 8'h55);
        chk("rb_sdio_t_phase", tbad, 0);
        chk("rb_sdio_t_after", sdio_t, 1);
        chk("rb_strobes", strobe_cnt, 5);

        spi_write(16'h04AA);
        chk("ab_format_loaded", reg_format, 8'hAA);
        spi_xfer(16'h0411, 10, 1'b1, rd, tbad);
        chk("ab_format_kept", reg_format, 8'hAA);
        chk("ab_frame_err", err_cnt, 1);
        chk("ab_no_strobe", strobe_cnt, 6);

        spi_write(16'h0000);
        chk("clr0_no_strobe", strobe_cnt, 6);
        chk("clr0_regs", {reg_pwr, reg_timing, reg_outmode, reg_format}, 32'h000155AA);
        spi_write(16'h0080);
        chk("clr_regs", {reg_pwr, reg_timing, reg_outmode, reg_format}, 32'h0);
        chk("clr_strobe", strobe_cnt, 7);
        chk("clr_wr_addr", wr_addr, 7'h00);

        spi_write(16'h0133);
        chk("um_pwr", reg_pwr, 8'h33);
        spi_write(16'h7F12);
        chk("um_no_strobe", strobe_cnt, 8);
        chk("um_wr_addr", wr_addr, 7'h01);
        chk("um_regs", {reg_pwr, reg_timing, reg_outmode, reg_format}, 32'h33000000);
        spi_xfer(16'h8500, 16, 1'b1, rd, tbad);
        chk("um_read", rd, 8'h00);
        spi_xfer(16'h8100, 16, 1'b1, rd, tbad);
        chk("pwr_read", rd, 8'h33);

        spi_xfer(16'h8100, 12, 1'b0, rd, tbad);
        wait_cyc(PH);
        chk("mr_driving", sdio_t, 0);
        aresetn = 1'b0;
        #1;
        chk("mr_sdio_t", sdio_t, 1);
        chk("mr_regs", {reg_pwr, reg_timing, reg_outmode, reg_format}, 32'h0);
        wait_cyc(3);
        aresetn = 1'b1;
        wait_cyc(PH);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1;
            wait_cyc(PH);
            sclk = 1'b0;
            wait_cyc(PH);
        end
        n_cs = 1'b1;
        wait_cyc(3 * PH);
        chk("mr_no_err", err_cnt, 1);
        chk("mr_no_strobe", strobe_cnt, 8);
        chk("mr_sdio_t_idle", sdio_t, 1);
        spi_write(16'h0201);
        chk("mr_timing", reg_timing, 8'h01);
        chk("mr_wr_addr", wr_addr, 7'h02);
        chk("mr_strobe", strobe_cnt, 9);
        chk("mr_others", {reg_pwr, reg_outmode, reg_format}, 24'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
